cache_fill_fsm: RTL

Cache miss fill controller that sits directly upstream of the memory interface. On a miss it fetches the whole 16-byte block (8 words) from the multicycle memory as pipelined back-to-back reads. It re-presents any issue slot the interface stalls, and streams returned words into the cache data array. After the last word it writes the tag and pulses a completion flag to the requesting stage.

---
 rtl/cache_fill_fsm.sv | 104 ++++++++++
 1 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches a whole block as pipelined reads, re-presents stalled
// issue slots, streams returned words into the data array and writes the tag at the end.
module cache_fill_fsm #(
    parameter int unsigned WORDS_PER_BLOCK = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               MissDetected,
    input  logic [15:0]                        MissAddress,
    input  logic                               MemStall,
    input  logic                               MemoryDataValid,
    input  logic [15:0]                        MemoryData,
    output logic                               MemoryRequest,
    output logic [15:0]                        MemoryAddress,
    output logic                               FsmBusy,
    output logic                               WriteDataArray,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] CacheWordIndex,
    output logic [15:0]                        CacheData,
    output logic                               WriteTagArray,
    output logic                               FillDone
);

    localparam int unsigned IdxW = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CntW = IdxW + 1;
    localparam logic [CntW-1:0] NumWords = CntW'(WORDS_PER_BLOCK);
    localparam logic [CntW-1:0] LastWord = CntW'(WORDS_PER_BLOCK - 1);
    // Blocks are 2*WORDS_PER_BLOCK bytes, so clear the byte-offset bits of the miss address.
    localparam logic [15:0] BaseMask = ~(16'(2 * WORDS_PER_BLOCK) - 16'd1);

    typedef enum logic {
        StIdle,
        StFill
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     block_base_q, block_base_d;
    logic [CntW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0] recv_cnt_q, recv_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            block_base_q <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            block_base_q <= block_base_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        block_base_d   = block_base_q;
        issue_cnt_d    = issue_cnt_q;
        recv_cnt_d     = recv_cnt_q;
        MemoryRequest  = 1'b0;
        MemoryAddress  = '0;
        FsmBusy        = 1'b0;
        WriteDataArray = 1'b0;
        CacheWordIndex = '0;
        CacheData      = '0;
        WriteTagArray  = 1'b0;
        FillDone       = 1'b0;

        case (state_q)
            StIdle: begin
                if (MissDetected) begin
                    block_base_d = MissAddress & BaseMask;
                    issue_cnt_d  = '0;
                    recv_cnt_d   = '0;
                    state_d      = StFill;
                end
            end
            StFill: begin
                FsmBusy = 1'b1;
                if (issue_cnt_q < NumWords) begin
                    MemoryRequest = 1'b1;
                    // OR rather than add: the offset never carries into the block base.
                    MemoryAddress = block_base_q | 16'({issue_cnt_q[IdxW-1:0], 1'b0});
                    if (!MemStall) begin
                        issue_cnt_d = issue_cnt_q + CntW'(1);
                    end
                end
                // Only accept data for reads that were actually issued.
                if (MemoryDataValid && (recv_cnt_q < issue_cnt_q)) begin
                    WriteDataArray = 1'b1;
                    CacheWordIndex = recv_cnt_q[IdxW-1:0];
                    CacheData      = MemoryData;
                    recv_cnt_d     = recv_cnt_q + CntW'(1);
                    if (recv_cnt_q == LastWord) begin
                        WriteTagArray = 1'b1;
                        FillDone      = 1'b1;
                        state_d       = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
